// File: rtl/hs_stream_arbiter.sv
// Packet-atomic arbiter that merges NUM_PORTS ap_hs requesters onto one registered AXI-Stream.
// Define HS_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module hs_stream_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int ACCID_WIDTH = 4,
  localparam int IDX_WIDTH  = $clog2(NUM_PORTS)
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [ACCID_WIDTH-1:0]      accID,
  input  logic [68*NUM_PORTS-1:0]     in_hs,
  input  logic [NUM_PORTS-1:0]        in_hs_ap_vld,
  output logic [NUM_PORTS-1:0]        in_hs_ap_ack,
  output logic [63:0]                 outStream_tdata,
  output logic [2:0]                  outStream_tdest,
  output logic [ACCID_WIDTH-1:0]      outStream_tid,
  output logic                        outStream_tlast,
  output logic                        outStream_tvalid,
  input  logic                        outStream_tready,
  output logic [IDX_WIDTH-1:0]        grant_idx,
  output logic                        busy
);

  localparam int BEAT_W = 68;
  localparam logic [NUM_PORTS-1:0] PORT0 = NUM_PORTS'(1);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]           state;
  logic [IDX_WIDTH-1:0] next_grant;
  logic                 any_vld;
  logic                 can_load;
  logic                 ack_any;
  logic [NUM_PORTS-1:0] grant_mask;
  logic [BEAT_W-1:0]    sel_beat;

`ifndef HS_ARB_FIXED_PRIO_EN
  logic [IDX_WIDTH-1:0] last_grant;

  // Scan last_grant+1, +2, ... with wrap-around; first requester found wins.
  always_comb begin
    next_grant = '0;
    any_vld    = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      int cand;
      cand = (int'(last_grant) + k) % NUM_PORTS;
      if (!any_vld && ((in_hs_ap_vld & (PORT0 << cand)) != '0)) begin
        any_vld    = 1'b1;
        next_grant = IDX_WIDTH'(cand);
      end
    end
  end
`else
  always_comb begin
    next_grant = '0;
    any_vld    = (in_hs_ap_vld != '0);
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((in_hs_ap_vld & (PORT0 << i)) != '0) begin
        next_grant = IDX_WIDTH'(i);
      end
    end
  end
`endif

  always_comb begin
    sel_beat = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx == IDX_WIDTH'(i)) begin
        sel_beat = in_hs[BEAT_W*i +: BEAT_W];
      end
    end
  end

  // Ack only the owner, and only when the output register is free or draining.
  assign grant_mask   = PORT0 << grant_idx;
  assign can_load     = !outStream_tvalid || outStream_tready;
  assign in_hs_ap_ack = ((state == ST_LOCKED) && can_load) ? (in_hs_ap_vld & grant_mask) : '0;
  assign ack_any      = (in_hs_ap_ack != '0);
  assign busy          = (state == ST_LOCKED);
  assign outStream_tid = accID;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state            <= ST_IDLE;
      grant_idx        <= '0;
      outStream_tvalid <= 1'b0;
      outStream_tdata  <= '0;
      outStream_tdest  <= '0;
      outStream_tlast  <= 1'b0;
`ifndef HS_ARB_FIXED_PRIO_EN
      last_grant       <= IDX_WIDTH'(NUM_PORTS - 1);
`endif
    end else begin
      if (ack_any) begin
        outStream_tdata  <= sel_beat[67:4];
        outStream_tdest  <= sel_beat[3:1];
        outStream_tlast  <= sel_beat[0];
        outStream_tvalid <= 1'b1;
      end else if (outStream_tvalid && outStream_tready) begin
        outStream_tvalid <= 1'b0;
      end

      if (state == ST_IDLE) begin
        if (any_vld) begin
          grant_idx <= next_grant;
          state     <= ST_LOCKED;
        end
      end else if (ack_any && sel_beat[0]) begin
        state <= ST_IDLE;
`ifndef HS_ARB_FIXED_PRIO_EN
        last_grant <= grant_idx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_hs_stream_arbiter.sv
// Directed self-checking bench for hs_stream_arbiter (4 ports, accID 0x5).
// Expected grant order follows HS_ARB_FIXED_PRIO_EN when defined.
module tb_hs_stream_arbiter;

  localparam int NUM_PORTS = 4;
  localparam int ACCID_WIDTH = 4;
  localparam int IDX_WIDTH = $clog2(NUM_PORTS);

  logic                       aclk;
  logic                       aresetn;
  logic [ACCID_WIDTH-1:0]     accID;
  logic [68*NUM_PORTS-1:0]    in_hs;
  logic [NUM_PORTS-1:0]       in_hs_ap_vld;
  logic [NUM_PORTS-1:0]       in_hs_ap_ack;
  logic [63:0]                outStream_tdata;
  logic [2:0]                 outStream_tdest;
  logic [ACCID_WIDTH-1:0]     outStream_tid;
  logic                       outStream_tlast;
  logic                       outStream_tvalid;
  logic                       outStream_tready;
  logic [IDX_WIDTH-1:0]       grant_idx;
  logic                       busy;

  int checks = 0;
  int errors = 0;

  hs_stream_arbiter #(.NUM_PORTS(NUM_PORTS), .ACCID_WIDTH(ACCID_WIDTH)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .accID(accID),
    .in_hs(in_hs),
    .in_hs_ap_vld(in_hs_ap_vld),
    .in_hs_ap_ack(in_hs_ap_ack),
    .outStream_tdata(outStream_tdata),
    .outStream_tdest(outStream_tdest),
    .outStream_tid(outStream_tid),
    .outStream_tlast(outStream_tlast),
    .outStream_tvalid(outStream_tvalid),
    .outStream_tready(outStream_tready),
    .grant_idx(grant_idx),
    .busy(busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic vld, input logic [63:0] data,
                               input logic [2:0] dest, input logic last);
    in_hs[68*port +: 68] = {data, dest, last};
    in_hs_ap_vld[port]   = vld;
  endtask

  task automatic waitCycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkLocked(input string tag, input int port, input logic tvalid_exp);
    checkOutput({tag, "_busy"}, 64'(busy), 64'(1'b1));
    checkOutput({tag, "_grant"}, 64'(grant_idx), 64'(port));
    checkOutput({tag, "_ack"}, 64'(in_hs_ap_ack), 64'(1) << port);
    checkOutput({tag, "_tvalid"}, 64'(outStream_tvalid), 64'(tvalid_exp));
  endtask

  task automatic checkBeat(input string tag, input logic [63:0] data, input logic last);
    checkOutput({tag, "_tvalid"}, 64'(outStream_tvalid), 64'(1'b1));
    checkOutput({tag, "_tdata"}, outStream_tdata, data);
    checkOutput({tag, "_tlast"}, 64'(outStream_tlast), 64'(last));
  endtask

  int exp_order [4];

  initial begin
`ifdef HS_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 3, 0};
`endif
    $display("[TB] start");
    aresetn          = 1'b0;
    accID            = 4'h5;
    in_hs            = '0;
    in_hs_ap_vld     = '0;
    outStream_tready = 1'b1;
    #2;
    checkOutput("rst_tvalid", 64'(outStream_tvalid), 64'(1'b0));
    checkOutput("rst_busy", 64'(busy), 64'(1'b0));
    checkOutput("rst_ack", 64'(in_hs_ap_ack), 64'(0));
    checkOutput("rst_grant", 64'(grant_idx), 64'(0));
    checkOutput("rst_tdata", outStream_tdata, 64'(0));
    checkOutput("tid", 64'(outStream_tid), 64'(4'h5));
    @(negedge aclk);
    aresetn = 1'b1;
    waitCycle();

    // Single 3-beat packet from port 2
    applyStimulus(2, 1'b1, 64'hA0, 3'd5, 1'b0);
    #1;
    checkOutput("p2_idle_ack", 64'(in_hs_ap_ack), 64'(0));
    waitCycle();
    checkLocked("p2_lock", 2, 1'b0);
    waitCycle();
    checkBeat("p2_b0", 64'hA0, 1'b0);
    checkOutput("p2_b0_tdest", 64'(outStream_tdest), 64'(3'd5));
    applyStimulus(2, 1'b1, 64'hA1, 3'd5, 1'b0);
    #1;
    checkOutput("p2_b1_ack", 64'(in_hs_ap_ack), 64'(4'b0100));
    waitCycle();
    checkBeat("p2_b1", 64'hA1, 1'b0);
    applyStimulus(2, 1'b1, 64'hA2, 3'd5, 1'b1);
    waitCycle();
    checkBeat("p2_b2", 64'hA2, 1'b1);
    checkOutput("p2_done_busy", 64'(busy), 64'(1'b0));
    applyStimulus(2, 1'b0, 64'h0, 3'd0, 1'b0);
    waitCycle();
    checkOutput("p2_drain", 64'(outStream_tvalid), 64'(1'b0));

    // Ports 0, 1, 3 contend with 1-beat packets after a fresh reset
    aresetn = 1'b0;
    #2;
    aresetn = 1'b1;
    applyStimulus(0, 1'b1, 64'hB0, 3'd1, 1'b1);
    applyStimulus(1, 1'b1, 64'hB1, 3'd1, 1'b1);
    applyStimulus(3, 1'b1, 64'hB3, 3'd1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      waitCycle();
      checkLocked($sformatf("rr%0d_lock", k), exp_order[k], 1'b0);
      waitCycle();
      checkBeat($sformatf("rr%0d_beat", k), 64'hB0 + 64'(exp_order[k]), 1'b1);
      checkOutput($sformatf("rr%0d_idle_ack", k), 64'(in_hs_ap_ack), 64'(0));
    end
    applyStimulus(0, 1'b0, 64'h0, 3'd0, 1'b0);
    waitCycle();
    checkLocked("p0idle_lock", 1, 1'b0);
    waitCycle();
    checkBeat("p0idle_beat", 64'hB1, 1'b1);
    applyStimulus(1, 1'b0, 64'h0, 3'd0, 1'b0);
    applyStimulus(3, 1'b0, 64'h0, 3'd0, 1'b0);
    waitCycle();
    checkOutput("rr_drain", 64'(outStream_tvalid), 64'(1'b0));

    // Port 1 sends 4 beats; port 0 requests mid-packet and must wait
    applyStimulus(1, 1'b1, 64'hC0, 3'd2, 1'b0);
    waitCycle();
    checkLocked("lk_lock", 1, 1'b0);
    waitCycle();
    checkBeat("lk_b0", 64'hC0, 1'b0);
    applyStimulus(1, 1'b1, 64'hC1, 3'd2, 1'b0);
    applyStimulus(0, 1'b1, 64'hD0, 3'd3, 1'b1);
    #1;
    checkOutput("lk_b1_ack", 64'(in_hs_ap_ack), 64'(4'b0010));
    waitCycle();
    checkBeat("lk_b1", 64'hC1, 1'b0);
    applyStimulus(1, 1'b1, 64'hC2, 3'd2, 1'b0);
    #1;
    checkOutput("lk_b2_ack", 64'(in_hs_ap_ack), 64'(4'b0010));
    waitCycle();
    checkBeat("lk_b2", 64'hC2, 1'b0);
    applyStimulus(1, 1'b1, 64'hC3, 3'd2, 1'b1);
    #1;
    checkOutput("lk_b3_ack", 64'(in_hs_ap_ack), 64'(4'b0010));
    waitCycle();
    checkBeat("lk_b3", 64'hC3, 1'b1);
    checkOutput("lk_idle_ack", 64'(in_hs_ap_ack), 64'(0));
    applyStimulus(1, 1'b0, 64'h0, 3'd0, 1'b0);
    waitCycle();
    checkLocked("lk_p0_lock", 0, 1'b0);
    waitCycle();
    checkBeat("lk_p0_beat", 64'hD0, 1'b1);
    checkOutput("lk_p0_tdest", 64'(outStream_tdest), 64'(3'd3));
    applyStimulus(0, 1'b0, 64'h0, 3'd0, 1'b0);
    waitCycle();
    checkOutput("lk_drain", 64'(outStream_tvalid), 64'(1'b0));

    // Backpressure on a 3-beat packet from port 2
    applyStimulus(2, 1'b1, 64'hE0, 3'd4, 1'b0);
    waitCycle();
    checkLocked("bp_lock", 2, 1'b0);
    waitCycle();
    checkBeat("bp_b0", 64'hE0, 1'b0);
    applyStimulus(2, 1'b1, 64'hE1, 3'd4, 1'b0);
    outStream_tready = 1'b0;
    #1;
    checkOutput("bp_stall_ack", 64'(in_hs_ap_ack), 64'(0));
    for (int c = 0; c < 5; c++) begin
      waitCycle();
      checkBeat($sformatf("bp_hold%0d", c), 64'hE0, 1'b0);
      checkOutput($sformatf("bp_hold%0d_ack", c), 64'(in_hs_ap_ack), 64'(0));
    end
    outStream_tready = 1'b1;
    #1;
    checkOutput("bp_release_ack", 64'(in_hs_ap_ack), 64'(4'b0100));
    waitCycle();
    checkBeat("bp_b1", 64'hE1, 1'b0);
    applyStimulus(2, 1'b1, 64'hE2, 3'd4, 1'b1);
    #1;
    checkOutput("bp_b2_ack", 64'(in_hs_ap_ack), 64'(4'b0100));
    waitCycle();
    checkBeat("bp_b2", 64'hE2, 1'b1);
    applyStimulus(2, 1'b0, 64'h0, 3'd0, 1'b0);
    waitCycle();
    checkOutput("bp_drain", 64'(outStream_tvalid), 64'(1'b0));

    // Asynchronous reset in the middle of a port 3 packet
    applyStimulus(3, 1'b1, 64'hF0, 3'd6, 1'b0);
    waitCycle();
    checkLocked("ar_lock", 3, 1'b0);
    waitCycle();
    checkBeat("ar_b0", 64'hF0, 1'b0);
    applyStimulus(3, 1'b1, 64'hF1, 3'd6, 1'b0);
    applyStimulus(0, 1'b1, 64'h90, 3'd7, 1'b1);
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("ar_tvalid", 64'(outStream_tvalid), 64'(1'b0));
    checkOutput("ar_ack", 64'(in_hs_ap_ack), 64'(0));
    checkOutput("ar_busy", 64'(busy), 64'(1'b0));
    @(posedge aclk);
    #3;
    aresetn = 1'b1;
    waitCycle();
    checkLocked("ar_rearb", 0, 1'b0);
    waitCycle();
    checkBeat("ar_p0_beat", 64'h90, 1'b1);
    applyStimulus(0, 1'b0, 64'h0, 3'd0, 1'b0);
    applyStimulus(3, 1'b0, 64'h0, 3'd0, 1'b0);
    waitCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_stream_arbiter.md
Name: hs_stream_arbiter

Overview:
- Shares one outgoing AXI-Stream (64-bit data, 3-bit tdest, tid, tlast) among NUM_PORTS ap_hs requesters of one accelerator.
- Each requester presents the 68-bit packed beat: [67:4] data, [3:1] dest, [0] last.
- Grants are packet-atomic: a granted port keeps the stream until its tlast beat is accepted. Round-robin fairness across packets.
- Output is registered: one beat per cycle at full throughput; no combinational path from outStream_tready to outStream_tvalid.

Parameters:
- NUM_PORTS, 4, number of hs requesters, 2..8.
- ACCID_WIDTH, 4, width of accID and outStream_tid.
- IDX_WIDTH, $clog2(NUM_PORTS), port index width (derived; do not override).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; asynchronous, active-low.
- accID  in  ACCID_WIDTH  static accelerator ID, driven on tid.
- in_hs  in  68*NUM_PORTS  packed beats; port i at [68*i+67:68*i].
- in_hs_ap_vld  in  NUM_PORTS  per-port valid.
- in_hs_ap_ack  out  NUM_PORTS  per-port ack; beat consumed when vld&&ack.
- outStream_tdata  out  64  registered data.
- outStream_tdest  out  3  registered dest.
- outStream_tid  out  ACCID_WIDTH  equals accID (combinational).
- outStream_tlast  out  1  registered last.
- outStream_tvalid  out  1  registered valid.
- outStream_tready  in  1  downstream ready.
- grant_idx  out  IDX_WIDTH  current owner; meaningful only when busy.
- busy  out  1  high in LOCKED.

Behaviour:
- Reset (async assert, sync release): state=IDLE, last_grant=NUM_PORTS-1, tvalid=0, tdata/tdest/tlast=0, grant_idx=0, busy=0, all acks 0.
- Mid-operation reset: the in-flight beat is dropped and the partial packet abandoned. The block does not resume it.
- State IDLE:
  - If any vld bit is set, pick the first set bit scanning last_grant+1, +2, ... modulo NUM_PORTS (wrap-around).
  - Load grant_idx and go to LOCKED.
  - This costs a one-cycle arbitration bubble per packet.
  - No ack is asserted in IDLE.
- State LOCKED:
  - ack[i] = (i==grant_idx) && vld[i] && (!tvalid || tready). Combinational, other ports 0.
  - On an ack, the output register loads the unpacked beat and tvalid=1.
  - If tvalid && tready and there is no ack, tvalid becomes 0.
  - Simultaneous drain and load: the register holds the new beat, tvalid stays 1.
  - Acking a beat with last=1 sets last_grant=grant_idx and returns to IDLE next cycle.
  - The output register may still hold that last beat in IDLE. It drains normally, and the new arbitration proceeds in parallel.
- Non-granted ports wait with ack=0 indefinitely. Their vld and data must be held (ap_hs rule).
- vld dropping on the granted port mid-packet keeps the lock. There is no timeout.
- Stream rule: while tvalid=1 && tready=0, tdata/tdest/tlast are held stable.
- Latency: an acked beat appears on the stream the next cycle.
- Throughput: packets of N beats from alternating ports cost N+1 cycles each.

Optional Feature:
- Macro HS_ARB_FIXED_PRIO_EN.
- Defined: IDLE arbitration is fixed priority, lowest set vld index wins. last_grant is not implemented.
- Undefined (default): round-robin as above.
- All other behaviour (locking, output register, reset) is identical.

Test Plan:
- Reset, then only port 2 sends 3 beats with data 0xA0..0xA2, last on the third, tready=1.
  - Expect grant_idx=2 one cycle after vld.
  - Stream shows 0xA0,0xA1,0xA2 in consecutive cycles, tlast only on 0xA2, tid=accID, tdest from bits [3:1].
- Ports 0,1,3 each hold a 1-beat packet simultaneously.
  - Round-robin grant order is 0,1,3,0...
  - With HS_ARB_FIXED_PRIO_EN: 0 repeatedly while it requests, 1 only when port 0 is idle.
- Port 1 mid-packet (beat 2 of 4) while port 0 raises vld.
  - Port 0 ack stays 0 until port 1's last beat is acked.
  - No interleaving on the stream.
- Backpressure: tready=0 for 5 cycles with tvalid=1.
  - tdata is held and no ack is asserted.
  - tready=1 then drains at 1 beat/cycle, and ack reasserts the same cycle.
- Assert aresetn low asynchronously mid-packet (between clock edges) with tvalid=1.
  - tvalid, acks and busy go 0 immediately, without a clock edge.
  - After release, the next arbitration starts from port 0.
